// File: rtl/sa_feed_ctrl.sv
// ---------------------------------------------------------------------------
// sa_feed_ctrl
//
// Sequencer for the systolic-array input path. On a start command it clears
// the PE accumulators, takes K row vectors from the operand buffer and
// forwards each one to the per-lane skew delay lines. It then waits for the
// array to fill and drain, and finally pulses done.
//
// Handshake: a vector moves from upstream in any cycle where i_vld and o_rdy
// are both high. o_rdy depends only on state: it is high for every FEED
// cycle and does not depend on i_vld. Upstream holds i_dat stable while
// i_vld is high. The skew lines have no back-pressure. o_row_vld marks a
// valid o_row_dat for exactly one cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_start       start pulse (ignored while o_busy)
//   i_cfg_k       number of vectors to feed, sampled with i_start
//   i_abort       abandon the current operation (no done pulse)
//   i_vld, i_dat  upstream vector stream; lane j = i_dat[j*DAT_WIDTH +: DAT_WIDTH]
//   o_rdy         upstream ready (combinational, high in FEED)
//   o_row_vld     vector valid into skew lines (registered)
//   o_row_dat     vector into skew lines (registered, held when invalid)
//   o_acc_clr     one-cycle accumulator clear, before the first vector
//   o_busy        operation in progress (state != IDLE)
//   o_done        one-cycle completion pulse
//   o_dbg_state   current FSM state, for observation only
// ---------------------------------------------------------------------------
module sa_feed_ctrl #(
    parameter int N         = 4,
    parameter int DAT_WIDTH = 16,
    parameter int K_WIDTH   = 8,
    parameter int PE_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [K_WIDTH-1:0]     i_cfg_k,
    input  logic                   i_abort,
    input  logic                   i_vld,
    input  logic [N*DAT_WIDTH-1:0] i_dat,
    output logic                   o_rdy,
    output logic                   o_row_vld,
    output logic [N*DAT_WIDTH-1:0] o_row_dat,
    output logic                   o_acc_clr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_dbg_state
);

    // Cycles from the last issued vector to the last PE result being valid.
    // It must be at least 1 so that done can be raised from a registered
    // compare.
    localparam int DRAIN_CYC = 2 * (N - 1) + PE_LAT;
    localparam int DRN_W     = $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0] DRAIN_LD = DRN_W'(DRAIN_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_FEED  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_WIDTH-1:0]  r_k;
    logic [K_WIDTH-1:0]  w_k_nxt;
    logic [K_WIDTH-1:0]  r_cnt;
    logic [K_WIDTH-1:0]  w_cnt_nxt;
    logic [DRN_W-1:0]    r_drn;
    logic [DRN_W-1:0]    w_drn_nxt;
    logic                w_row_vld_nxt;
    logic                w_acc_clr_nxt;
    logic                w_done_nxt;
    logic                w_xfer;
    logic                w_last;

    assign o_rdy       = (r_state == S_FEED);
    assign o_dbg_state = r_state;
    assign w_xfer      = o_rdy && i_vld;
    // k is never 0 outside IDLE, so k-1 does not wrap here.
    assign w_last      = w_xfer && (r_cnt == r_k - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of registered outputs
    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_cnt_nxt     = r_cnt;
        w_drn_nxt     = r_drn;
        w_row_vld_nxt = 1'b0;
        w_acc_clr_nxt = 1'b0;
        w_done_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_cfg_k != '0) begin
                        w_k_nxt       = i_cfg_k;
                        w_state_nxt   = S_CLR;
                        w_acc_clr_nxt = 1'b1;
                    end else begin
                        // Empty job: complete at once without leaving IDLE.
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_FEED;
            end
            S_FEED: begin
                if (w_xfer) begin
                    w_row_vld_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DRAIN;
                        w_drn_nxt   = DRAIN_LD;
                    end
                end
            end
            S_DRAIN: begin
                // The counter is DRAIN_CYC in the cycle of the last o_row_vld.
                // Done is registered at 1, so it appears DRAIN_CYC cycles
                // later. That is the final DRAIN cycle, where the count is 0.
                if (r_drn == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drn_nxt = r_drn - DRN_W'(1);
                    if (r_drn == DRN_W'(1)) begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides everything, including a transfer in the same
        // cycle as the last vector.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_row_vld_nxt = 1'b0;
            w_acc_clr_nxt = 1'b0;
            w_done_nxt    = 1'b0;
        end
    end

    // Counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_cnt     <= '0;
            r_drn     <= '0;
            o_row_vld <= 1'b0;
            o_row_dat <= '0;
            o_acc_clr <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            r_k       <= w_k_nxt;
            r_cnt     <= w_cnt_nxt;
            r_drn     <= w_drn_nxt;
            o_row_vld <= w_row_vld_nxt;
            if (w_row_vld_nxt) begin
                o_row_dat <= i_dat;
            end
            o_acc_clr <= w_acc_clr_nxt;
            o_busy    <= (w_state_nxt != S_IDLE);
            o_done    <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sa_feed_ctrl
//
// Directed scenarios followed by random traffic. Expected outputs come from
// an event-time model of one job:
//   - the start cycle s
//   - the number of accepted vectors
//   - the cycle of the last transfer
// From these:
//   - clear is expected at s+1
//   - ready is expected from s+2 until k vectors have been accepted
//   - done is expected at (last transfer)+1+DRAIN
// Accepted vectors go into exp_q and are compared one cycle later.
// ---------------------------------------------------------------------------
module tb_sa_feed_ctrl;
  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int KW     = 8;
  localparam int PE_LAT = 1;
  localparam int DRAIN  = 2 * (N - 1) + PE_LAT;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [KW-1:0] i_cfg_k = '0;
  logic          i_abort = 1'b0;
  logic          i_vld = 1'b0;
  logic [N*DW-1:0] i_dat = '0;
  logic          o_rdy, o_row_vld, o_acc_clr, o_busy, o_done;
  logic [N*DW-1:0] o_row_dat;
  logic [1:0]    o_dbg_state;

  sa_feed_ctrl #(.N(N), .DAT_WIDTH(DW), .K_WIDTH(KW), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_k(i_cfg_k),
    .i_abort(i_abort), .i_vld(i_vld), .i_dat(i_dat),
    .o_rdy(o_rdy), .o_row_vld(o_row_vld), .o_row_dat(o_row_dat),
    .o_acc_clr(o_acc_clr), .o_busy(o_busy), .o_done(o_done),
    .o_dbg_state(o_dbg_state)
  );

  // scoreboard / model state
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit m_op = 0;          // a job is in progress (busy)
  int m_start = 0;
  int m_k = 0;
  int m_acc = 0;
  int m_last = -1;
  bit m_zdone = 0;       // k=0 start seen last cycle
  bit m_vld_next = 0;    // a vector was accepted last cycle
  bit m_after_rst = 0;
  bit e_busy = 0, e_rdy = 0, e_clr = 0, e_vld = 0, e_done = 0;
  logic [N*DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
  endtask

  // Apply one cycle of inputs, advance the model, then check the outputs
  // of the following cycle.
  task automatic step(input bit s, input int k, input bit ab, input bit v, input bit r);
    logic [N*DW-1:0] d;
    logic [N*DW-1:0] ed;
    bit busy;
    d = {$urandom, $urandom};
    rst = r; i_start = s; i_cfg_k = k[KW-1:0]; i_abort = ab; i_vld = v; i_dat = d;

    m_zdone = 0;
    m_vld_next = 0;
    m_after_rst = r;
    if (r) begin
      m_op = 0;
      exp_q.delete();
    end else begin
      busy = m_op;
      if (e_rdy && v && !ab) begin
        m_vld_next = 1;
        exp_q.push_back(d);
        m_acc++;
        if (m_acc == m_k) m_last = cyc;
      end
      if (busy && (ab || (m_acc == m_k && cyc == m_last + 1 + DRAIN))) m_op = 0;
      if (!busy && s) begin
        if (k == 0) m_zdone = 1;
        else begin
          m_op = 1; m_start = cyc; m_k = k; m_acc = 0; m_last = -1;
        end
      end
    end

    @(posedge clk);
    #1;
    cyc++;

    e_busy = m_op;
    e_clr  = m_op && (cyc == m_start + 1);
    e_rdy  = m_op && (cyc >= m_start + 2) && (m_acc < m_k);
    e_vld  = m_vld_next;
    e_done = m_zdone || (m_op && m_acc == m_k && cyc == m_last + 1 + DRAIN);

    check_val("busy", o_busy, e_busy);
    check_val("rdy", o_rdy, e_rdy);
    check_val("acc_clr", o_acc_clr, e_clr);
    check_val("row_vld", o_row_vld, e_vld);
    check_val("done", o_done, e_done);
    if (e_vld && exp_q.size() > 0) begin
      ed = exp_q.pop_front();
      check_val("row_dat", o_row_dat, ed);
    end
    if (m_after_rst) check_val("row_dat_rst", o_row_dat, '0);
  endtask

  task automatic idle(input int n, input bit v);
    for (int i = 0; i < n; i++) step(0, 0, 0, v, 0);
  endtask

  initial begin : main
    bit r, s, ab, v;
    int k;
    bit pat[7];

    // reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    idle(2, 0);

    // basic, k=3, valid held high
    step(1, 3, 0, 1, 0);
    idle(14, 1);

    // bubbles, k=4
    pat = '{1, 0, 0, 1, 1, 0, 1};
    step(1, 4, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, pat[i], 0);
    idle(10, 0);

    // k=0
    step(1, 0, 0, 1, 0);
    idle(3, 1);

    // abort in the third FEED cycle, then a k=1 job
    step(1, 5, 0, 1, 0);
    idle(3, 1);
    step(0, 0, 1, 1, 0);
    idle(3, 1);
    step(1, 1, 0, 1, 0);
    idle(12, 1);

    // start while busy (during DRAIN)
    step(1, 2, 0, 1, 0);
    idle(3, 1);
    step(1, 9, 0, 1, 0);
    idle(10, 1);

    // sync reset mid-FEED
    step(1, 6, 0, 1, 0);
    idle(3, 1);
    step(0, 0, 0, 1, 1);
    idle(4, 1);

    // maximum k, no wrap
    step(1, 255, 0, 1, 0);
    idle(270, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 4) == 0);
      k  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 6);
      ab = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 2) != 0);
      step(s, k, ab, v, r);
    end
    idle(300, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
